// File: rtl/module_bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit saturating counters,
// F->D->E prediction pipeline, and Execute-stage resolution/redirect.
module module_bpu #(
    parameter int INDEX_BITS = 4,
    parameter int XLEN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            enable_i,
    input  logic [XLEN-1:0] pcf_i,
    output logic            predict_taken_f_o,
    output logic [XLEN-1:0] predicted_pc_f_o,
    input  logic            stalld_i,
    input  logic            flushd_i,
    input  logic            flushe_i,
    input  logic            branche_i,
    input  logic            jumpe_i,
    input  logic            pcsrce_i,
    input  logic [XLEN-1:0] pce_i,
    input  logic [XLEN-1:0] pctargete_i,
    output logic            prediction_bit_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = XLEN - INDEX_BITS - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic              fd_pred_q, fd_pred_d;
    logic [XLEN-1:0]   fd_tgt_q, fd_tgt_d;
    logic              de_pred_q, de_pred_d;
    logic [XLEN-1:0]   de_tgt_q, de_tgt_d;

    logic [INDEX_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]      tag_f, tag_e;
    logic                  hit_f, hit_e;
    logic                  resolve_e;
    logic [1:0]            ctr_e;

    // PC bits [1:0] never participate in indexing or tagging
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = &{1'b0, pcf_i[1:0], pce_i[1:0]};

    assign idx_f     = pcf_i[INDEX_BITS+1:2];
    assign tag_f     = pcf_i[XLEN-1:INDEX_BITS+2];
    assign idx_e     = pce_i[INDEX_BITS+1:2];
    assign tag_e     = pce_i[XLEN-1:INDEX_BITS+2];
    assign hit_f     = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e     = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign resolve_e = branche_i | jumpe_i;
    assign ctr_e     = ctr_q[idx_e];

    // Fetch lookup reads the registered table, so a same-cycle update is not seen
    always_comb begin
        predict_taken_f_o = enable_i & hit_f & ctr_q[idx_f][1];
        predicted_pc_f_o  = predict_taken_f_o ? target_q[idx_f] : pcf_i + XLEN'(4);
    end

    // Execute resolution: wrong direction, wrong target, or a prediction on a non-branch
    always_comb begin
        mispredict_o  = (resolve_e && (pcsrce_i != de_pred_q))
                     || (resolve_e && pcsrce_i && de_pred_q && (de_tgt_q != pctargete_i))
                     || (de_pred_q && !resolve_e);
        redirect_pc_o = pcsrce_i ? pctargete_i : pce_i + XLEN'(4);
    end

    // Table update from the resolved instruction in Execute
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (resolve_e) begin
            if (hit_e) begin
                if (jumpe_i) begin
                    ctr_d[idx_e]    = 2'b11;
                    target_d[idx_e] = pctargete_i;
                end else if (pcsrce_i) begin
                    ctr_d[idx_e]    = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'd1;
                    target_d[idx_e] = pctargete_i;
                end else begin
                    ctr_d[idx_e]    = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'd1;
                end
            end else if (pcsrce_i) begin
                valid_d[idx_e]  = 1'b1;
                tag_d[idx_e]    = tag_e;
                target_d[idx_e] = pctargete_i;
                ctr_d[idx_e]    = jumpe_i ? 2'b11 : 2'b10;
            end
        end else if (de_pred_q && hit_e) begin
            valid_d[idx_e] = 1'b0;
        end
    end

    // Prediction pipeline: flush beats stall in D
    always_comb begin
        fd_pred_d = fd_pred_q;
        fd_tgt_d  = fd_tgt_q;
        if (flushd_i) begin
            fd_pred_d = 1'b0;
            fd_tgt_d  = '0;
        end else if (!stalld_i) begin
            fd_pred_d = predict_taken_f_o;
            fd_tgt_d  = predicted_pc_f_o;
        end
        de_pred_d = flushe_i ? 1'b0 : fd_pred_q;
        de_tgt_d  = flushe_i ? '0   : fd_tgt_q;
    end

    assign prediction_bit_o = de_pred_q;

    // BTB storage; counters reset to weakly not-taken
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    // F->D and D->E prediction registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fd_pred_q <= 1'b0;
            fd_tgt_q  <= '0;
            de_pred_q <= 1'b0;
            de_tgt_q  <= '0;
        end else begin
            fd_pred_q <= fd_pred_d;
            fd_tgt_q  <= fd_tgt_d;
            de_pred_q <= de_pred_d;
            de_tgt_q  <= de_tgt_d;
        end
    end

endmodule

// File: tb/tb_module_bpu.sv
// Directed bench for module_bpu with hand-computed expectations.
module tb_module_bpu;

    localparam logic [31:0] IDLE_PC = 32'h0000_0008;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        enable_i;
    logic [31:0] pcf_i;
    logic        predict_taken_f_o;
    logic [31:0] predicted_pc_f_o;
    logic        stalld_i, flushd_i, flushe_i;
    logic        branche_i, jumpe_i, pcsrce_i;
    logic [31:0] pce_i, pctargete_i;
    logic        prediction_bit_o, mispredict_o;
    logic [31:0] redirect_pc_o;

    int n_chk  = 0;
    int n_pass = 0;

    module_bpu #(.INDEX_BITS(4), .XLEN(32)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .enable_i         (enable_i),
        .pcf_i            (pcf_i),
        .predict_taken_f_o(predict_taken_f_o),
        .predicted_pc_f_o (predicted_pc_f_o),
        .stalld_i         (stalld_i),
        .flushd_i         (flushd_i),
        .flushe_i         (flushe_i),
        .branche_i        (branche_i),
        .jumpe_i          (jumpe_i),
        .pcsrce_i         (pcsrce_i),
        .pce_i            (pce_i),
        .pctargete_i      (pctargete_i),
        .prediction_bit_o (prediction_bit_o),
        .mispredict_o     (mispredict_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_e();
        branche_i   = 1'b0;
        jumpe_i     = 1'b0;
        pcsrce_i    = 1'b0;
        pce_i       = '0;
        pctargete_i = '0;
    endtask

    // Combinational fetch lookup at pc, then back to a missing address before any edge
    task automatic probe(input string tag, input logic [31:0] pc,
                         input logic exp_tk, input logic [31:0] exp_pc);
        pcf_i = pc;
        #1;
        check({tag, "_taken"}, {31'b0, predict_taken_f_o}, {31'b0, exp_tk});
        check({tag, "_pc"}, predicted_pc_f_o, exp_pc);
        pcf_i = IDLE_PC;
    endtask

    task automatic resolve(input logic br, input logic jmp, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt);
        branche_i   = br;
        jumpe_i     = jmp;
        pcsrce_i    = tk;
        pce_i       = pc;
        pctargete_i = tgt;
        step();
        clear_e();
    endtask

    initial begin
        rst_n_i  = 1'b0;
        enable_i = 1'b1;
        stalld_i = 1'b0;
        flushd_i = 1'b0;
        flushe_i = 1'b0;
        clear_e();
        pcf_i = 32'h100;
        #2;
        check("rst_taken", {31'b0, predict_taken_f_o}, 32'd0);
        check("rst_pc", predicted_pc_f_o, 32'h104);
        check("rst_pbit", {31'b0, prediction_bit_o}, 32'd0);
        check("rst_misp", {31'b0, mispredict_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // first taken branch: miss, mispredict, lookup still sees old entry
        branche_i = 1'b1; pcsrce_i = 1'b1; pce_i = 32'h100; pctargete_i = 32'h80;
        #1;
        check("alloc_misp", {31'b0, mispredict_o}, 32'd1);
        check("alloc_redir", redirect_pc_o, 32'h80);
        check("same_cyc_taken", {31'b0, predict_taken_f_o}, 32'd0);
        pcf_i = IDLE_PC;
        step();
        clear_e();
        probe("alloc", 32'h100, 1'b1, 32'h80);

        // not-taken resolution without prediction: no mispredict
        branche_i = 1'b1; pcsrce_i = 1'b0; pce_i = 32'h100;
        #1;
        check("nt_misp", {31'b0, mispredict_o}, 32'd0);
        check("nt_redir", redirect_pc_o, 32'h104);
        step();
        clear_e();
        probe("ctr01", 32'h100, 1'b0, 32'h104);
        resolve(1, 0, 0, 32'h100, 32'h0);
        resolve(1, 0, 0, 32'h100, 32'h0);
        resolve(1, 0, 1, 32'h100, 32'h80);
        probe("sat_lo", 32'h100, 1'b0, 32'h104);
        resolve(1, 0, 1, 32'h100, 32'h80);
        probe("ctr10", 32'h100, 1'b1, 32'h80);
        resolve(1, 0, 1, 32'h100, 32'h80);
        resolve(1, 0, 1, 32'h100, 32'h80);
        resolve(1, 0, 0, 32'h100, 32'h0);
        probe("sat_hi", 32'h100, 1'b1, 32'h80);

        // prediction reaches E two edges after fetch
        pcf_i = 32'h100;
        step();
        pcf_i = IDLE_PC;
        check("lat1_pbit", {31'b0, prediction_bit_o}, 32'd0);
        step();
        check("lat2_pbit", {31'b0, prediction_bit_o}, 32'd1);
        branche_i = 1'b1; pcsrce_i = 1'b1; pce_i = 32'h100; pctargete_i = 32'h80;
        #1;
        check("tgt_ok_misp", {31'b0, mispredict_o}, 32'd0);
        pctargete_i = 32'h84;
        #1;
        check("tgt_bad_misp", {31'b0, mispredict_o}, 32'd1);
        check("tgt_bad_redir", redirect_pc_o, 32'h84);
        pcsrce_i = 1'b0;
        #1;
        check("pt_nt_misp", {31'b0, mispredict_o}, 32'd1);
        check("pt_nt_redir", redirect_pc_o, 32'h104);
        step();
        clear_e();
        probe("dec_hit", 32'h100, 1'b0, 32'h104);

        // stall with bubble in E, then stale prediction on a non-branch
        resolve(1, 0, 1, 32'h100, 32'h80);
        pcf_i = 32'h100;
        step();
        pcf_i = IDLE_PC;
        stalld_i = 1'b1; flushe_i = 1'b1;
        step();
        check("stall1_pbit", {31'b0, prediction_bit_o}, 32'd0);
        step();
        check("stall2_pbit", {31'b0, prediction_bit_o}, 32'd0);
        stalld_i = 1'b0; flushe_i = 1'b0;
        step();
        check("release_pbit", {31'b0, prediction_bit_o}, 32'd1);
        pce_i = 32'h100;
        #1;
        check("stale_misp", {31'b0, mispredict_o}, 32'd1);
        check("stale_redir", redirect_pc_o, 32'h104);
        step();
        clear_e();
        probe("stale_clr", 32'h100, 1'b0, 32'h104);

        // flush beats stall in D
        resolve(1, 0, 1, 32'h100, 32'h80);
        pcf_i = 32'h100;
        step();
        pcf_i = IDLE_PC;
        stalld_i = 1'b1; flushd_i = 1'b1; flushe_i = 1'b1;
        step();
        stalld_i = 1'b0; flushd_i = 1'b0; flushe_i = 1'b0;
        step();
        check("flush_prio_pbit", {31'b0, prediction_bit_o}, 32'd0);

        // enable gating
        enable_i = 1'b0;
        probe("dis", 32'h100, 1'b0, 32'h104);
        enable_i = 1'b1;
        probe("en", 32'h100, 1'b1, 32'h80);

        // asynchronous reset mid-operation, away from any edge
        rst_n_i = 1'b0;
        probe("async_rst", 32'h100, 1'b0, 32'h104);
        rst_n_i = 1'b1;

        // jumps and index aliasing
        resolve(0, 1, 1, 32'h40, 32'h200);
        probe("jal40", 32'h40, 1'b1, 32'h200);
        probe("alias80", 32'h80, 1'b0, 32'h84);
        resolve(0, 1, 1, 32'h80, 32'h300);
        probe("jal80", 32'h80, 1'b1, 32'h300);
        probe("evict40", 32'h40, 1'b0, 32'h44);
        probe("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/module_bpu.md
# module_bpu

Branch prediction unit for the RV32I five-stage pipeline. It does three things:
- Looks up the Fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and supplies a predicted next PC to the Fetch mux.
- Carries the prediction bit and predicted target through the D and E pipeline registers. The E-stage bit is the `prediction_bit_i` consumed by the hazard unit.
- Resolves branches and jumps in Execute: it updates the table and raises a mispredict redirect.

## Interface

Parameters:
- `INDEX_BITS`, default 4: BTB index width (2^INDEX_BITS entries).
- `XLEN`, default 32: PC width.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: prediction enable. When 0, every Fetch prediction is not-taken; table updates continue.
- `pcf_i` in XLEN: Fetch-stage PC.
- `predict_taken_f_o` out 1: Fetch prediction, combinational.
- `predicted_pc_f_o` out XLEN: BTB target if `predict_taken_f_o`, else `pcf_i+4`.
- `stalld_i` in 1: hold the F→D prediction register.
- `flushd_i` in 1: clear the F→D prediction register.
- `flushe_i` in 1: clear the D→E prediction register.
- `branche_i` in 1: E-stage instruction is a conditional branch.
- `jumpe_i` in 1: E-stage instruction is JAL/JALR.
- `pcsrce_i` in 1: actual taken outcome in E.
- `pce_i` in XLEN: E-stage instruction PC.
- `pctargete_i` in XLEN: actual resolved target in E.
- `prediction_bit_o` out 1: E-stage prediction bit (to the hazard unit).
- `mispredict_o` out 1: E-stage misprediction, combinational.
- `redirect_pc_o` out XLEN: correct next PC on mispredict.

## Operation

BTB entry contents: `valid`, `tag` (PC[XLEN-1 : INDEX_BITS+2]), `target` (XLEN bits), `ctr` (2 bits).
- Index is PC[INDEX_BITS+1 : 2].
- Hit = `valid` & tag match.

Fetch lookup (combinational):
- `predict_taken_f_o` = `enable_i` & hit & `ctr[1]`.

Pipeline registers, each holding {pred, target}:
- F→D: `flushd_i` loads zero and has priority over `stalld_i`. `stalld_i` holds the current value. Otherwise it captures the Fetch lookup.
- D→E: `flushe_i` loads zero. Otherwise it captures F→D.
- `prediction_bit_o` = the E-register pred.

Resolution in E (combinational):
- `mispredict_o` asserts when any of these holds:
  - (`branche_i`|`jumpe_i`) & (`pcsrce_i` ≠ pred_e)
  - (`branche_i`|`jumpe_i`) & `pcsrce_i` & pred_e & (target_e ≠ `pctargete_i`)
  - pred_e & !`branche_i` & !`jumpe_i` (stale entry on a non-branch).
- `redirect_pc_o` = `pcsrce_i` ? `pctargete_i` : `pce_i`+4. This value is valid whenever `mispredict_o` is high.

Table update on the clock edge, only when `branche_i`|`jumpe_i`, indexed and tagged by `pce_i`:
- Hit, conditional branch: `ctr` saturating-increments if taken, saturating-decrements if not taken (00↔11 clamp). `target` is rewritten with `pctargete_i` when taken.
- Hit, jump: `ctr`=11, `target`=`pctargete_i`.
- Miss, taken: allocate. `valid`=1, tag from `pce_i`, `target`=`pctargete_i`, `ctr`=10 for branches and 11 for jumps.
- Miss, not taken: no write.
- Stale entry (pred_e on a non-branch): clear `valid` at index(`pce_i`) if the tag matches.

Arithmetic: all PC adds are XLEN-bit and wrap modulo 2^XLEN.

## Timing

- Reset (async, `rst_n_i`=0):
  - All `valid`=0, all `ctr`=01, all tags and targets 0.
  - Both pipeline registers are 0.
  - Therefore `prediction_bit_o`=0 and `predict_taken_f_o`=0. `mispredict_o` is 0 unless E inputs flag a taken branch.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- Lookup latency: 0 cycles (combinational). The prediction reaches `prediction_bit_o` 2 edges after Fetch, absent stalls and flushes.
- Update latency: the write is visible to a lookup from the edge after resolution.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update entry.
- Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
- Index aliasing: the tag mismatch forces not-taken. An allocation overwrites the aliased entry.
- `stalld_i` and `flushd_i` together: the flush wins.

## Test plan

- Reset with `pcf_i`=0x100 → `predict_taken_f_o`=0, `predicted_pc_f_o`=0x104, `prediction_bit_o`=0.
- Branch at 0x100 resolved taken to 0x80 (pred 0) → `mispredict_o`=1, `redirect_pc_o`=0x80. Next cycle, `pcf_i`=0x100 → predicted 0x80 (`ctr`=10).
- Same branch resolved not-taken twice → `ctr` 10→01→00. Lookup gives not-taken; a third not-taken leaves `ctr`=00.
- Predicted-taken branch resolves not-taken at `pce_i`=0x100 → `mispredict_o`=1, `redirect_pc_o`=0x104.
- Taken entry at 0x100, then `stalld_i`=1 for 2 cycles, then `flushe_i` pulse → `prediction_bit_o` stays 0 through the bubble. The pred=1 reaches E only after the stall releases.
- JAL at 0x40 with `pctargete_i`=0x200, then an alias at 0x40+(16<<2)=0x80 → 0x80 predicts not-taken. A taken JAL at 0x80 overwrites the entry and 0x40 then misses.
